hcordic_vector: RTL and testbench

HCORDIC_VECTOR -- requirements
Module: hcordic_vector

---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/hcordic_vec_step.sv | 28 ++
 rtl/hcordic_vector.sv | 112 +++++++++++
 tb/tb_hcordic_vector.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - Q8.8 format, step schedule, atanh table and FSM states for hyperbolic CORDIC
package cordic_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 8;
  localparam int N_STEP = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shift 4 is repeated so the hyperbolic sequence converges.
  function automatic logic [3:0] shift_seq(input logic [3:0] idx);
    case (idx)
      4'd0:    shift_seq = 4'd1;
      4'd1:    shift_seq = 4'd2;
      4'd2:    shift_seq = 4'd3;
      4'd3:    shift_seq = 4'd4;
      4'd4:    shift_seq = 4'd4;
      4'd5:    shift_seq = 4'd5;
      4'd6:    shift_seq = 4'd6;
      4'd7:    shift_seq = 4'd7;
      default: shift_seq = 4'd8;
    endcase
  endfunction

  function automatic logic signed [Q_W-1:0] atanh_lut(input logic [3:0] s);
    case (s)
      4'd1:    atanh_lut = 16'sd141;
      4'd2:    atanh_lut = 16'sd65;
      4'd3:    atanh_lut = 16'sd32;
      4'd4:    atanh_lut = 16'sd16;
      4'd5:    atanh_lut = 16'sd8;
      4'd6:    atanh_lut = 16'sd4;
      4'd7:    atanh_lut = 16'sd2;
      4'd8:    atanh_lut = 16'sd1;
      default: atanh_lut = 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/hcordic_vec_step.sv
// rtl/hcordic_vec_step.sv - one combinational hyperbolic vectoring micro-rotation
module hcordic_vec_step
  import cordic_pkg::*;
(
  input  logic signed [Q_W-1:0] i_x,
  input  logic signed [Q_W-1:0] i_y,
  input  logic signed [Q_W-1:0] i_z,
  input  logic        [3:0]     i_shift,
  input  logic signed [Q_W-1:0] i_t,
  output logic signed [Q_W-1:0] o_x,
  output logic signed [Q_W-1:0] o_y,
  output logic signed [Q_W-1:0] o_z
);

  logic signed [Q_W-1:0] w_xs;
  logic signed [Q_W-1:0] w_ys;
  logic                  w_y_pos;

  assign w_xs    = i_x >>> i_shift;
  assign w_ys    = i_y >>> i_shift;
  assign w_y_pos = ~i_y[Q_W-1];

  // Both updates use the pre-step x and y; sums wrap in 16 bits.
  assign o_x = w_y_pos ? (i_x - w_ys) : (i_x + w_ys);
  assign o_y = w_y_pos ? (i_y - w_xs) : (i_y + w_xs);
  assign o_z = w_y_pos ? (i_z + i_t)  : (i_z - i_t);

endmodule

// File: rtl/hcordic_vector.sv
// rtl/hcordic_vector.sv - iterative hyperbolic CORDIC vectoring unit with valid/ready handshakes
module hcordic_vector
  import cordic_pkg::*;
#(
  parameter int N_STEP = cordic_pkg::N_STEP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [Q_W-1:0] x_in,
  input  logic signed [Q_W-1:0] y_in,
  input  logic signed [Q_W-1:0] z_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [Q_W-1:0] x_out,
  output logic signed [Q_W-1:0] y_out,
  output logic signed [Q_W-1:0] z_out,
  output logic                  err
);

  localparam logic [3:0] LAST_STEP = 4'(N_STEP - 1);

  state_t                r_state;
  logic        [3:0]     r_step;
  logic signed [Q_W-1:0] r_x;
  logic signed [Q_W-1:0] r_y;
  logic signed [Q_W-1:0] r_z;
  logic                  r_err;

  logic        [3:0]     w_shift;
  logic signed [Q_W-1:0] w_t;
  logic signed [Q_W-1:0] w_nx;
  logic signed [Q_W-1:0] w_ny;
  logic signed [Q_W-1:0] w_nz;
  logic signed [Q_W:0]   w_x_ext;
  logic signed [Q_W:0]   w_y_ext;
  logic signed [Q_W:0]   w_abs_y;
  logic                  w_domain_bad;

  assign w_shift = shift_seq(r_step);
  assign w_t     = atanh_lut(w_shift);

  hcordic_vec_step u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (w_shift),
    .i_t     (w_t),
    .o_x     (w_nx),
    .o_y     (w_ny),
    .o_z     (w_nz)
  );

  // One extra bit so |y| of the most negative operand does not overflow.
  assign w_x_ext      = {x_in[Q_W-1], x_in};
  assign w_y_ext      = {y_in[Q_W-1], y_in};
  assign w_abs_y      = w_y_ext[Q_W] ? -w_y_ext : w_y_ext;
  assign w_domain_bad = (w_x_ext <= 0) || (w_abs_y >= w_x_ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_step  <= 4'd0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x    <= x_in;
            r_y    <= y_in;
            r_z    <= z_in;
            r_step <= 4'd0;
            if (w_domain_bad) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_x    <= w_nx;
          r_y    <= w_ny;
          r_z    <= w_nz;
          r_step <= r_step + 4'd1;
          if (r_step == LAST_STEP) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign x_out     = r_x;
  assign y_out     = r_y;
  assign z_out     = r_z;
  assign err       = r_err;

endmodule

// File: tb/tb_hcordic_vector.sv
// tb/tb_hcordic_vector.sv - directed vector bench for the hyperbolic CORDIC vectoring unit
module tb_hcordic_vector;

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic signed [15:0] ex;
    logic signed [15:0] ey;
    logic signed [15:0] ez;
    logic               eerr;
    int                 elat;
    logic               chk_xyz;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic signed [15:0] z_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic signed [15:0] z_out;
  logic               err;

  int checks = 0;
  int errors = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  hcordic_vector dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .err       (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    int lat;
    logic signed [15:0] sx, sy, sz;
    logic serr;
    @(negedge clk);
    chk("in_ready_before_accept", int'(in_ready), 1);
    x_in = v.x; y_in = v.y; z_in = v.z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, v.elat);
    chk("err", int'(err), int'(v.eerr));
    if (v.chk_xyz) begin
      chk("x_out", int'(x_out), int'(v.ex));
      chk("y_out", int'(y_out), int'(v.ey));
      chk("z_out", int'(z_out), int'(v.ez));
    end
    sx = x_out; sy = y_out; sz = z_out; serr = err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      x_in = 16'sd512; y_in = 16'sd0; z_in = 16'sd99; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_stable", int'({x_out, y_out, z_out, err} == {sx, sy, sz, serr}), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    vecs[0] = '{16'sd256,   16'sd128,    16'sd0,  16'sd182,  16'sd0,      16'sd141, 1'b0, 9, 1'b1};
    vecs[1] = '{16'sd256,  -16'sd128,    16'sd64, 16'sd182,  16'sd0,     -16'sd77,  1'b0, 9, 1'b1};
    vecs[2] = '{16'sd512,   16'sd0,      16'sd0,  16'sd421, -16'sd2,      16'sd1,   1'b0, 9, 1'b1};
    vecs[3] = '{16'sd256,   16'sd256,    16'sd5,  16'sd256,  16'sd256,    16'sd5,   1'b1, 0, 1'b1};
    vecs[4] = '{-16'sd10,   16'sd3,      16'sd7, -16'sd10,   16'sd3,      16'sd7,   1'b1, 0, 1'b1};
    vecs[5] = '{16'sd0,     16'sd0,      16'sd0,  16'sd0,    16'sd0,      16'sd0,   1'b1, 0, 1'b1};
    vecs[6] = '{16'sd256,  -16'sd256,   -16'sd9,  16'sd256, -16'sd256,   -16'sd9,   1'b1, 0, 1'b1};
    vecs[7] = '{16'sd256,   16'sd255,    16'sd0,  16'sd0,    16'sd0,      16'sd0,   1'b0, 9, 1'b0};
    vecs[8] = '{16'sd100,  -16'sd32768,  16'sd1,  16'sd100, -16'sd32768,  16'sd1,   1'b1, 0, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_outputs", int'({x_out, y_out, z_out, err} == 49'd0), 1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 0);

    // Result held under backpressure while new operands are offered.
    run_vec(vecs[1], 5);
    run_vec(vecs[3], 5);

    // Back-to-back operands with in_valid held high.
    begin
      int k, r, last;
      k = 0; r = 0; last = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && r < 3; cyc++) begin
        @(negedge clk);
        if (out_valid) begin
          chk("b2b_x", int'(x_out), int'(vecs[r].ex));
          chk("b2b_y", int'(y_out), int'(vecs[r].ey));
          chk("b2b_z", int'(z_out), int'(vecs[r].ez));
          r++;
        end
        if (k < 3) begin
          x_in = vecs[k].x; y_in = vecs[k].y; z_in = vecs[k].z; in_valid = 1'b1;
          if (in_ready) begin
            if (k > 0) chk("b2b_spacing_ge11", int'(cyc - last >= 11), 1);
            last = cyc;
            k++;
          end
        end else begin
          in_valid = 1'b0;
        end
      end
      chk("b2b_results", r, 3);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
    end

    // Reset partway through RUN abandons the operation.
    @(negedge clk);
    x_in = vecs[1].x; y_in = vecs[1].y; z_in = vecs[1].z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrun_reset_out_valid", int'(out_valid), 0);
    chk("midrun_reset_in_ready", int'(in_ready), 1);
    chk("midrun_reset_outputs", int'({x_out, y_out, z_out, err} == 49'd0), 1);
    repeat (12) @(posedge clk);
    #1 chk("midrun_no_result", int'(out_valid), 0);
    run_vec(vecs[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
